// File: rtl/reg_bank_pkg.sv
// Shared constants for the register bank: widths, address map, ALU cc codes
// and instruction-register field positions.
package reg_bank_pkg;

    localparam int DATA_BUS_WIDTH   = 32;
    localparam int REG_BUS_WIDTH    = 6;
    localparam int ALU_BUS_WIDTH    = 4;
    localparam int FLAGS_BUS_WIDTH  = 4;
    localparam int DECODE_BUS_WIDTH = 8;
    localparam int NUM_REGS         = 38;

    // Register address map
    localparam logic [5:0] REG_R0    = 6'd0;
    localparam logic [5:0] REG_PC    = 6'd32;
    localparam logic [5:0] REG_TEMP0 = 6'd33;
    localparam logic [5:0] REG_TEMP1 = 6'd34;
    localparam logic [5:0] REG_TEMP2 = 6'd35;
    localparam logic [5:0] REG_TEMP3 = 6'd36;
    localparam logic [5:0] REG_IR    = 6'd37;
    localparam logic [5:0] REG_LAST  = 6'd37;

    // ALU function codes that update the flag register
    localparam logic [3:0] ALU_ANDCC = 4'b0000;
    localparam logic [3:0] ALU_ORCC  = 4'b0001;
    localparam logic [3:0] ALU_NORCC = 4'b0010;
    localparam logic [3:0] ALU_ADDCC = 4'b0011;

    // IR field bit positions
    localparam int IR_OP_HI   = 31;
    localparam int IR_OP_LO   = 30;
    localparam int IR_RD_HI   = 29;
    localparam int IR_RD_LO   = 25;
    localparam int IR_OP3_HI  = 24;
    localparam int IR_OP3_LO  = 19;
    localparam int IR_RS1_HI  = 18;
    localparam int IR_RS1_LO  = 14;
    localparam int IR_BIT13   = 13;
    localparam int IR_RS2_HI  = 4;
    localparam int IR_RS2_LO  = 0;

    // True when the ALU code is one of the condition-code setting operations
    function automatic logic is_cc_code(input logic [3:0] alu);
        logic hit;
        case (alu)
            ALU_ANDCC, ALU_ORCC, ALU_NORCC, ALU_ADDCC: hit = 1'b1;
            default:                                   hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/reg_bank_if.sv
// Micro-control <-> register bank bus: selects, write sources, flags and decode.
interface reg_bank_if;
    import reg_bank_pkg::*;

    logic [REG_BUS_WIDTH-1:0]    reg_bank_A_IN;
    logic [REG_BUS_WIDTH-1:0]    reg_bank_B_IN;
    logic [REG_BUS_WIDTH-1:0]    reg_bank_C_IN;
    logic                        reg_bank_AMUX_IN;
    logic                        reg_bank_BMUX_IN;
    logic                        reg_bank_CMUX_IN;
    logic                        reg_bank_RD_IN;
    logic [ALU_BUS_WIDTH-1:0]    reg_bank_ALU_IN;
    logic [DATA_BUS_WIDTH-1:0]   reg_bank_ALUResult_IN;
    logic [FLAGS_BUS_WIDTH-1:0]  reg_bank_ALUFlags_IN;
    logic [DATA_BUS_WIDTH-1:0]   reg_bank_MemData_IN;
    logic [DATA_BUS_WIDTH-1:0]   reg_bank_A_BUS_OUT;
    logic [DATA_BUS_WIDTH-1:0]   reg_bank_B_BUS_OUT;
    logic [FLAGS_BUS_WIDTH-1:0]  reg_bank_FLAGs_OUT;
    logic                        reg_bank_IR13_OUT;
    logic [DECODE_BUS_WIDTH-1:0] reg_bank_Decode_OUT;

    // Micro-control side
    modport master (
        output reg_bank_A_IN, reg_bank_B_IN, reg_bank_C_IN,
        output reg_bank_AMUX_IN, reg_bank_BMUX_IN, reg_bank_CMUX_IN,
        output reg_bank_RD_IN, reg_bank_ALU_IN, reg_bank_ALUResult_IN,
        output reg_bank_ALUFlags_IN, reg_bank_MemData_IN,
        input  reg_bank_A_BUS_OUT, reg_bank_B_BUS_OUT, reg_bank_FLAGs_OUT,
        input  reg_bank_IR13_OUT, reg_bank_Decode_OUT
    );

    // Register bank side
    modport slave (
        input  reg_bank_A_IN, reg_bank_B_IN, reg_bank_C_IN,
        input  reg_bank_AMUX_IN, reg_bank_BMUX_IN, reg_bank_CMUX_IN,
        input  reg_bank_RD_IN, reg_bank_ALU_IN, reg_bank_ALUResult_IN,
        input  reg_bank_ALUFlags_IN, reg_bank_MemData_IN,
        output reg_bank_A_BUS_OUT, reg_bank_B_BUS_OUT, reg_bank_FLAGs_OUT,
        output reg_bank_IR13_OUT, reg_bank_Decode_OUT
    );

endinterface

// File: rtl/reg_bank_addr_mux.sv
// Resolves the effective A/B/C register selects: either the direct select
// from micro-control or the corresponding 5-bit IR field zero-extended.
module reg_bank_addr_mux
    import reg_bank_pkg::*;
(
    input  logic [5:0] a_sel_i,
    input  logic [5:0] b_sel_i,
    input  logic [5:0] c_sel_i,
    input  logic       amux_i,
    input  logic       bmux_i,
    input  logic       cmux_i,
    input  logic [4:0] ir_rs1_i,
    input  logic [4:0] ir_rs2_i,
    input  logic [4:0] ir_rd_i,
    output logic [5:0] a_eff_o,
    output logic [5:0] b_eff_o,
    output logic [5:0] c_eff_o
);

    // Pick direct select or IR field for each of the three ports
    always_comb begin
        a_eff_o = a_sel_i;
        b_eff_o = b_sel_i;
        c_eff_o = c_sel_i;
        if (amux_i) begin
            a_eff_o = {1'b0, ir_rs1_i};
        end else begin
            a_eff_o = a_sel_i;
        end
        if (bmux_i) begin
            b_eff_o = {1'b0, ir_rs2_i};
        end else begin
            b_eff_o = b_sel_i;
        end
        if (cmux_i) begin
            c_eff_o = {1'b0, ir_rd_i};
        end else begin
            c_eff_o = c_sel_i;
        end
    end

endmodule

// File: rtl/reg_bank.sv
// Architectural register bank: %r0-%r31, %pc, %temp0-3, %ir, plus the N/Z/V/C
// flag register. Two combinational read ports, one clocked write port.
module reg_bank
    import reg_bank_pkg::*;
(
    input  logic       reg_bank_CLOCK_50,
    input  logic       reg_bank_RESET_InHigh,
    reg_bank_if.slave  rb
);

    logic [DATA_BUS_WIDTH-1:0]  regs_q [0:NUM_REGS-1];
    logic [DATA_BUS_WIDTH-1:0]  regs_d [0:NUM_REGS-1];
    logic [FLAGS_BUS_WIDTH-1:0] flags_q;
    logic [FLAGS_BUS_WIDTH-1:0] flags_d;

    logic [5:0]                 a_eff;
    logic [5:0]                 b_eff;
    logic [5:0]                 c_eff;
    logic                       wr_en;
    logic [DATA_BUS_WIDTH-1:0]  wr_data;

    reg_bank_addr_mux u_addr_mux (
        .a_sel_i  (rb.reg_bank_A_IN),
        .b_sel_i  (rb.reg_bank_B_IN),
        .c_sel_i  (rb.reg_bank_C_IN),
        .amux_i   (rb.reg_bank_AMUX_IN),
        .bmux_i   (rb.reg_bank_BMUX_IN),
        .cmux_i   (rb.reg_bank_CMUX_IN),
        .ir_rs1_i (regs_q[REG_IR][IR_RS1_HI:IR_RS1_LO]),
        .ir_rs2_i (regs_q[REG_IR][IR_RS2_HI:IR_RS2_LO]),
        .ir_rd_i  (regs_q[REG_IR][IR_RD_HI:IR_RD_LO]),
        .a_eff_o  (a_eff),
        .b_eff_o  (b_eff),
        .c_eff_o  (c_eff)
    );

    // Write source select and enable: %r0 and unimplemented addresses drop writes
    always_comb begin
        wr_en   = (c_eff != REG_R0) && (c_eff <= REG_LAST);
        wr_data = rb.reg_bank_ALUResult_IN;
        if (rb.reg_bank_RD_IN) begin
            wr_data = rb.reg_bank_MemData_IN;
        end else begin
            wr_data = rb.reg_bank_ALUResult_IN;
        end
    end

    // Next-state of the storage array and flag register
    always_comb begin
        regs_d  = regs_q;
        flags_d = flags_q;
        if (wr_en) begin
            regs_d[c_eff] = wr_data;
        end else begin
            regs_d = regs_q;
        end
        if (is_cc_code(rb.reg_bank_ALU_IN)) begin
            flags_d = rb.reg_bank_ALUFlags_IN;
        end else begin
            flags_d = flags_q;
        end
    end

    // State update; synchronous reset clears every register and the flags
    always_ff @(posedge reg_bank_CLOCK_50) begin
        if (reg_bank_RESET_InHigh) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            flags_q <= '0;
        end else begin
            regs_q  <= regs_d;
            flags_q <= flags_d;
        end
    end

    // Combinational read ports; %r0 and unimplemented addresses read as zero
    always_comb begin
        rb.reg_bank_A_BUS_OUT = '0;
        rb.reg_bank_B_BUS_OUT = '0;
        if ((a_eff != REG_R0) && (a_eff <= REG_LAST)) begin
            rb.reg_bank_A_BUS_OUT = regs_q[a_eff];
        end else begin
            rb.reg_bank_A_BUS_OUT = '0;
        end
        if ((b_eff != REG_R0) && (b_eff <= REG_LAST)) begin
            rb.reg_bank_B_BUS_OUT = regs_q[b_eff];
        end else begin
            rb.reg_bank_B_BUS_OUT = '0;
        end
    end

    // Flags and IR-derived decode fields for the micro-control unit
    always_comb begin
        rb.reg_bank_FLAGs_OUT  = flags_q;
        rb.reg_bank_IR13_OUT   = regs_q[REG_IR][IR_BIT13];
        rb.reg_bank_Decode_OUT = {regs_q[REG_IR][IR_OP_HI:IR_OP_LO],
                                  regs_q[REG_IR][IR_OP3_HI:IR_OP3_LO]};
    end

endmodule
